// File: rtl/dpu_shift_sequencer.sv
// dpu_shift_sequencer
// Control sequencer feeding the DPU data-validation stage. It accepts one
// vector operation (vl + reduction flag), emits a one-cycle load strobe,
// shifts ceil(vl/VLANE_NUM) lane beats under downstream backpressure, and
// optionally drains VLANE_NUM-1 partial reduction results. It finishes
// with a single-cycle done pulse.
module dpu_shift_sequencer #(
  parameter int unsigned MAX_VL_PER_LANE = 256,
  parameter int unsigned VLANE_NUM       = 8,
  localparam int unsigned VLW = $clog2(VLANE_NUM * MAX_VL_PER_LANE),
  localparam int unsigned CW  = $clog2(MAX_VL_PER_LANE) + 1,
  localparam int unsigned LW  = $clog2(VLANE_NUM)
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           start_i,
  input  logic [VLW-1:0] vl_i,
  input  logic           reduction_i,
  input  logic           out_ready_i,
  output logic           ready_o,
  output logic           load_o,
  output logic [VLW-1:0] vl_o,
  output logic           shift_en_o,
  output logic           shift_partial_o,
  output logic           done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PARTIAL,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [VLW-1:0] r_vl;
  logic [VLW-1:0] w_vl_nxt;
  logic           r_red;
  logic           w_red_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CW-1:0]  w_beats;
  logic           w_last;

  // Lane beats for the captured vl: vl / VLANE_NUM, rounded up.
  assign w_beats = CW'(r_vl[VLW-1:LW]) + CW'(|r_vl[LW-1:0]);

  // The counter is at its final accepted transfer.
  assign w_last = (r_cnt == CW'(1));

  // Register the state, the operation fields and the beat counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_vl    <= '0;
      r_red   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vl    <= w_vl_nxt;
      r_red   <= w_red_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Compute the next state, the operation capture and the counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_vl_nxt    = r_vl;
    w_red_nxt   = r_red;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_vl_nxt    = vl_i;
          w_red_nxt   = reduction_i;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_nxt   = w_beats;
        w_state_nxt = (w_beats == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (out_ready_i) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (w_last) begin
            if (r_red) begin
              w_cnt_nxt   = CW'(VLANE_NUM - 1);
              w_state_nxt = S_PARTIAL;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_PARTIAL: begin
        if (out_ready_i) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decode the outputs. Only the shift strobes see out_ready_i directly.
  always_comb begin
    ready_o         = 1'b0;
    load_o          = 1'b0;
    shift_en_o      = 1'b0;
    shift_partial_o = 1'b0;
    done_o          = 1'b0;
    unique case (r_state)
      S_IDLE:    ready_o         = 1'b1;
      S_LOAD:    load_o          = 1'b1;
      S_SHIFT:   shift_en_o      = out_ready_i;
      S_PARTIAL: shift_partial_o = out_ready_i;
      S_DONE:    done_o          = 1'b1;
      default:   ready_o         = 1'b0;
    endcase
  end

  assign vl_o = r_vl;

endmodule

// File: doc/dpu_shift_sequencer.md
# dpu_shift_sequencer

Control sequencer directly upstream of the DPU data-validation stage. It accepts one vector operation (vector length plus reduction flag) and generates the `load`, `shift_en` and `shift_partial` strobe sequence, along with the stable vector length, that the validation stage and the lane shift registers consume. The main shift phase is throttled by downstream backpressure. Completion is reported with a single-cycle pulse.

## Interface
- `MAX_VL_PER_LANE`, default 256: maximum elements per lane.
- `VLANE_NUM`, default 8: number of lanes. Must be a power of two and at least 2.
- `clk_i`, input, 1: clock. All flops are rising-edge.
- `rstn_i`, input, 1: reset. Asynchronous and active-low.
- `start_i`, input, 1: request a new operation. Sampled only in IDLE.
- `vl_i`, input, `$clog2(VLANE_NUM*MAX_VL_PER_LANE)`: vector length. Captured with `start_i`.
- `reduction_i`, input, 1: operation is a reduction, so partial results are drained after the main shift. Captured with `start_i`.
- `out_ready_i`, input, 1: downstream can accept a lane beat this cycle.
- `ready_o`, output, 1: sequencer is in IDLE and can accept `start_i`.
- `load_o`, output, 1: one-cycle load strobe to validation and lanes.
- `vl_o`, output, same width as `vl_i`: captured vector length. Held constant from LOAD until the next accepted start.
- `shift_en_o`, output, 1: shift one full lane beat.
- `shift_partial_o`, output, 1: shift one partial reduction result.
- `done_o`, output, 1: one-cycle completion pulse.

## Operation
- Beat count: `beats = ceil(vl/VLANE_NUM) = (vl >> log2(VLANE_NUM)) + (vl[log2(VLANE_NUM)-1:0] != 0)`.
  - Computed on the captured vl.
  - Counter width is `$clog2(MAX_VL_PER_LANE)+1`, so the maximum vl of `VLANE_NUM*MAX_VL_PER_LANE-1` gives `MAX_VL_PER_LANE` beats with no overflow.
- States are IDLE, LOAD, SHIFT, PARTIAL and DONE.
- IDLE
  - `ready_o=1`; all strobes 0.
  - On `start_i=1`: capture `vl_i` into `vl_o` and capture `reduction_i`, then go to LOAD.
- LOAD
  - `load_o=1` for exactly one cycle; `ready_o=0`.
  - Beat counter is loaded with `beats`.
  - Next state: if `beats==0` go to DONE (a reduction with vl=0 skips PARTIAL), otherwise go to SHIFT.
- SHIFT
  - `shift_en_o = out_ready_i`, combinational.
  - Each cycle with `shift_en_o=1` decrements the counter.
  - On the beat that takes the counter to 0: go to PARTIAL (counter loaded with `VLANE_NUM-1`) if reduction, otherwise go to DONE.
  - Stalls (`out_ready_i=0`) hold state and counter indefinitely.
- PARTIAL
  - `shift_partial_o = out_ready_i`.
  - Each accepted cycle decrements the counter.
  - After `VLANE_NUM-1` accepted cycles, go to DONE.
- DONE
  - `done_o=1` for one cycle, then go to IDLE.
- `start_i` outside IDLE is ignored and not queued.
- `shift_en_o` and `shift_partial_o` are never high in the same cycle.
- Neither of them is ever high in the same cycle as `load_o`.
- `vl_o` never changes outside the IDLE-to-LOAD capture edge, because the downstream stage also samples vl as a registered copy after load.

## Timing
- Reset values: state IDLE, `ready_o=1`, `load_o=0`, `shift_en_o=0`, `shift_partial_o=0`, `done_o=0`, `vl_o=0`, counter 0.
- Reset mid-operation aborts immediately and asynchronously. No `done_o` is produced.
- Start latency: `start_i` sampled at edge k gives `load_o` high during cycle k+1.
- The first `shift_en_o` can occur at cycle k+2.
- Unstalled total from the start edge to the `done_o` cycle: `1 + beats + (red && beats ? VLANE_NUM-1 : 0) + 1` cycles.
- `ready_o` returns to 1 in the cycle after `done_o`.
- Back-to-back operations: `start_i` held high gives one idle cycle between `done_o` and the next `load_o`.
- The only combinational input-to-output paths are `out_ready_i` to `shift_en_o` and `out_ready_i` to `shift_partial_o`.
- Every other output is decoded from registered state.

## Test plan
- vl=20, red=0, `out_ready_i=1`, VLANE_NUM=8:
  - `load_o` is high for 1 cycle, then `shift_en_o` for 3 consecutive cycles, then `done_o`.
  - `vl_o`=20 is held throughout.
  - `shift_partial_o` is never asserted.
- vl=5, red=1:
  - 1 `shift_en_o` beat, then 7 consecutive `shift_partial_o` cycles, then `done_o`.
  - Total is 10 cycles from the start edge.
- vl=0 with red=1: `load_o`, then `done_o` on the next cycle, with zero shift or partial strobes.
- vl=16, red=1, `out_ready_i` toggling 1,0,0,1,0,1…:
  - Exactly 2 `shift_en_o` and 7 `shift_partial_o` pulses, each coinciding with `out_ready_i=1`.
  - The counter holds during stalls.
  - `start_i` pulsed mid-operation is ignored.
- Max vl=2047: exactly 256 `shift_en_o` beats, with no counter wrap.
- Reset mid-SHIFT after 2 of 5 beats:
  - All outputs are 0 immediately, `ready_o=1` and `vl_o=0`.
  - No `done_o` is produced.
  - A following start of vl=8 produces 1 beat correctly.
